// File: rtl/demux_seq_pkg.sv
// Shared types for the serial-frame demux sequencer.
// Build option: DEMUX_SEQ_PARITY_EN adds a trailing even-parity beat.
package demux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_e;

    // Counter must reach the longer of the address and payload phases.
    function automatic int cnt_w(input int payload_len, input int sel_w);
        int n;
        n = (payload_len > sel_w) ? payload_len : sel_w;
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Beat counter: clear, increment, and terminal-count compare.
module seq_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/demux_frame_sequencer.sv
// Serial frame (start, address, payload) to 1xN demux select/data driver.
// Build option: DEMUX_SEQ_PARITY_EN enables the parity beat and frame_err.
module demux_frame_sequencer
    import demux_seq_pkg::*;
#(
    parameter int SEL_W       = 2,
    parameter int PAYLOAD_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_bit,
    input  logic             rx_valid,
    output logic [SEL_W-1:0] sel,
    output logic             din,
    output logic             din_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err
);

    localparam int CW = cnt_w(PAYLOAD_LEN, SEL_W);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             din_q, din_d;
    logic             dv_q, dv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clr, cnt_inc, cnt_tc;
    logic [CW-1:0]    cnt_last;
`ifdef DEMUX_SEQ_PARITY_EN
    logic             err_q, err_d;
    logic             par_q, par_d;
`endif

    assign cnt_last = (state_q == ADDR) ? CW'(SEL_W - 1)
                                        : CW'(PAYLOAD_LEN - 1);

    seq_bit_counter #(.W(CW)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .last_i (cnt_last),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        din_d   = 1'b0;
        dv_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
`ifdef DEMUX_SEQ_PARITY_EN
        err_d   = 1'b0;
        par_d   = par_q;
`endif
        if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_bit) begin
                        state_d = ADDR;
                        busy_d  = 1'b1;
                        cnt_clr = 1'b1;
`ifdef DEMUX_SEQ_PARITY_EN
                        par_d   = 1'b0;
`endif
                    end
                end
                ADDR: begin
                    // Shadow register keeps sel stable until the address is whole.
                    addr_d = SEL_W'({addr_q, rx_bit});
`ifdef DEMUX_SEQ_PARITY_EN
                    par_d  = par_q ^ rx_bit;
`endif
                    if (cnt_tc) begin
                        sel_d   = addr_d;
                        state_d = DATA;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                DATA: begin
                    din_d = rx_bit;
                    dv_d  = 1'b1;
`ifdef DEMUX_SEQ_PARITY_EN
                    par_d = par_q ^ rx_bit;
`endif
                    if (cnt_tc) begin
                        cnt_clr = 1'b1;
`ifdef DEMUX_SEQ_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
`ifdef DEMUX_SEQ_PARITY_EN
                PARITY: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (par_q ^ rx_bit) begin
                        err_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            din_q   <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            din_q   <= din_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef DEMUX_SEQ_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            par_q <= 1'b0;
        end else begin
            err_q <= err_d;
            par_q <= par_d;
        end
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign sel        = sel_q;
    assign din        = din_q;
    assign din_valid  = dv_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Scoreboard bench for demux_frame_sequencer (default or parity build).
module tb_demux_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_bit = 1'b0;
    logic       rx_valid = 1'b0;
    logic [1:0] sel;
    logic       din, din_valid, busy, frame_done, frame_err;

    typedef struct packed {
        logic [1:0] sel;
        logic       din;
        logic       done;
    } beat_t;

    beat_t      exp_q[$];
    logic [1:0] res_q[$];
    int         checks = 0;
    int         failures = 0;

    demux_frame_sequencer #(.SEL_W(2), .PAYLOAD_LEN(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_bit     (rx_bit),
        .rx_valid   (rx_valid),
        .sel        (sel),
        .din        (din),
        .din_valid  (din_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        beat_t      e;
        logic [1:0] r;
        if (rst_n) begin
            chk("done_err_excl", 32'(frame_done & frame_err), 32'd0);
            if (din_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_din_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sel", 32'(sel), 32'(e.sel));
                    chk("din", 32'(din), 32'(e.din));
                    chk("done_at_beat", 32'(frame_done), 32'(e.done));
                end
            end else begin
                chk("din_idle_zero", 32'(din), 32'd0);
            end
            if (frame_done || frame_err) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_frame_end", 32'd1, 32'd0);
                end else begin
                    r = res_q.pop_front();
                    chk("frame_end", 32'({frame_err, frame_done}), 32'(r));
                end
            end
        end
    end

    task automatic beat(input logic b);
        rx_valid = 1'b1;
        rx_bit   = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_bit   = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            chk("busy_in_gap", 32'(busy), 32'd1);
            @(negedge clk);
        end
    endtask

    // nbeats < 8 truncates the frame (used for the reset-abort case).
    task automatic send_frame(input logic [1:0] a, input logic [7:0] p,
                              input int g, input int nbeats,
                              input logic bad_par);
        logic pb;
        logic last;
        for (int i = 0; i < nbeats; i++) begin
            last = (i == 7);
`ifdef DEMUX_SEQ_PARITY_EN
            last = 1'b0;
`endif
            exp_q.push_back({a, p[7-i], last});
        end
        if (nbeats == 8) begin
`ifdef DEMUX_SEQ_PARITY_EN
            res_q.push_back(bad_par ? 2'b10 : 2'b01);
`else
            res_q.push_back(2'b01);
`endif
        end
        beat(1'b1);
        for (int i = 1; i >= 0; i--) begin
            gap(g);
            beat(a[i]);
        end
        for (int i = 7; i > 7 - nbeats; i--) begin
            gap(g);
            beat(p[i]);
        end
`ifdef DEMUX_SEQ_PARITY_EN
        if (nbeats == 8) begin
            pb = ^{a, p};
            gap(g);
            beat(pb ^ bad_par);
        end
`else
        pb = bad_par;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dv", 32'(din_valid), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle-line zeros must never start a frame.
        for (int i = 0; i < 20; i++) begin
            beat(1'b0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_dv", 32'(din_valid), 32'd0);
            chk("idle_sel", 32'(sel), 32'd0);
        end

        send_frame(2'b10, 8'b10110011, 0, 8, 1'b0);
        repeat (3) @(negedge clk);
        chk("sel_hold", 32'(sel), 32'd2);
        chk("busy_after", 32'(busy), 32'd0);

        send_frame(2'b10, 8'b10110011, 3, 8, 1'b0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) beat(1'b0);
        send_frame(2'b11, 8'b01011100, 0, 8, 1'b0);
        send_frame(2'b00, 8'b11100101, 0, 8, 1'b0);
        repeat (3) @(negedge clk);
        chk("sel_b2b", 32'(sel), 32'd0);

        send_frame(2'b11, 8'b11010010, 0, 4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_sel", 32'(sel), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dv", 32'(din_valid), 32'd0);
        chk("abort_din", 32'(din), 32'd0);
        chk("abort_done", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(2'b01, 8'b00110110, 1, 8, 1'b0);
        repeat (3) @(negedge clk);
        chk("sel_after_rst", 32'(sel), 32'd1);

`ifdef DEMUX_SEQ_PARITY_EN
        send_frame(2'b01, 8'h0F, 0, 8, 1'b0);
        send_frame(2'b01, 8'h0F, 0, 8, 1'b1);
        repeat (3) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("res_q_drained", 32'(res_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
